// File: rtl/mod_exp_ctrl.sv
// Square-and-multiply sequencer for base^exponent mod modulus.
// Forms raw products and delegates every reduction to an external mod_operation unit.
module mod_exp_ctrl #(
    parameter int WIDTH = 32,
    parameter int KEY_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [KEY_W-1:0] base,
    input  logic [KEY_W-1:0] exponent,
    input  logic [KEY_W-1:0] modulus,
    output logic [KEY_W-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             mod_ena,
    output logic [WIDTH-1:0] mod_a,
    output logic [WIDTH-1:0] mod_b,
    input  logic [WIDTH-1:0] mod_result,
    input  logic             mod_done
);

    typedef enum logic [3:0] {
        IDLE, RED_REQ, RED_WAIT, CHECK, MUL_REQ, MUL_WAIT, SQR_REQ, SQR_WAIT, FIN
    } state_t;

    state_t           state_q, state_d;
    logic [KEY_W-1:0] b_q, b_d, e_q, e_d, n_q, n_d, acc_q, acc_d;
    logic [KEY_W-1:0] result_q, result_d;
    logic             busy_q, busy_d, done_q, done_d, error_q, error_d, mod_ena_q, mod_ena_d;
    logic [WIDTH-1:0] mod_a_q, mod_a_d, mod_b_q, mod_b_d;

    logic [2*KEY_W-1:0] prod_mul, prod_sqr;
    logic [KEY_W-1:0]   rem;

    // Zero-extend a double-width product onto the mod_operation bus.
    function automatic logic [WIDTH-1:0] widen(input logic [2*KEY_W-1:0] v);
        logic [WIDTH-1:0] w;
        w = '0;
        w[2*KEY_W-1:0] = v;
        return w;
    endfunction

    assign prod_mul = {{KEY_W{1'b0}}, acc_q} * {{KEY_W{1'b0}}, b_q};
    assign prod_sqr = {{KEY_W{1'b0}}, b_q} * {{KEY_W{1'b0}}, b_q};
    assign rem      = mod_result[KEY_W-1:0];

    always_comb begin
        state_d   = state_q;
        b_d       = b_q;
        e_d       = e_q;
        n_d       = n_q;
        acc_d     = acc_q;
        result_d  = result_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = error_q;
        mod_ena_d = 1'b0;
        mod_a_d   = mod_a_q;
        mod_b_d   = mod_b_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    b_d     = base;
                    e_d     = exponent;
                    n_d     = modulus;
                    acc_d   = KEY_W'(1);
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = (modulus == '0) ? FIN : RED_REQ;
                end
            end
            RED_REQ: begin
                mod_a_d   = widen({{KEY_W{1'b0}}, b_q});
                mod_b_d   = widen({{KEY_W{1'b0}}, n_q});
                mod_ena_d = 1'b1;
                state_d   = RED_WAIT;
            end
            RED_WAIT: begin
                if (mod_done) begin
                    b_d     = rem;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (e_q == '0)      state_d = FIN;
                else if (e_q[0])    state_d = MUL_REQ;
                else                state_d = SQR_REQ;
            end
            MUL_REQ: begin
                mod_a_d   = widen(prod_mul);
                mod_b_d   = widen({{KEY_W{1'b0}}, n_q});
                mod_ena_d = 1'b1;
                state_d   = MUL_WAIT;
            end
            MUL_WAIT: begin
                if (mod_done) begin
                    acc_d = rem;
                    // Skip the trailing square once no exponent bits remain.
                    if ((e_q >> 1) != '0) begin
                        state_d = SQR_REQ;
                    end else begin
                        e_d     = '0;
                        state_d = CHECK;
                    end
                end
            end
            SQR_REQ: begin
                mod_a_d   = widen(prod_sqr);
                mod_b_d   = widen({{KEY_W{1'b0}}, n_q});
                mod_ena_d = 1'b1;
                state_d   = SQR_WAIT;
            end
            SQR_WAIT: begin
                if (mod_done) begin
                    b_d     = rem;
                    e_d     = e_q >> 1;
                    state_d = CHECK;
                end
            end
            FIN: begin
                result_d = (n_q <= KEY_W'(1)) ? '0 : acc_q;
                error_d  = (n_q == '0);
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            b_q       <= '0;
            e_q       <= '0;
            n_q       <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            mod_ena_q <= 1'b0;
            mod_a_q   <= '0;
            mod_b_q   <= '0;
        end else begin
            state_q   <= state_d;
            b_q       <= b_d;
            e_q       <= e_d;
            n_q       <= n_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            mod_ena_q <= mod_ena_d;
            mod_a_q   <= mod_a_d;
            mod_b_q   <= mod_b_d;
        end
    end

    assign result  = result_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;
    assign mod_ena = mod_ena_q;
    assign mod_a   = mod_a_q;
    assign mod_b   = mod_b_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl with a variable-latency mod_operation stand-in.
module tb_mod_exp_ctrl;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] base, exponent, modulus, result;
    logic        busy, done, error, mod_ena, mod_done;
    logic [31:0] mod_a, mod_b, mod_result;

    always #5 clk = ~clk;

    mod_exp_ctrl #(.WIDTH(32), .KEY_W(16)) dut (
        .clock(clk), .reset(reset), .start(start),
        .base(base), .exponent(exponent), .modulus(modulus),
        .result(result), .busy(busy), .done(done), .error(error),
        .mod_ena(mod_ena), .mod_a(mod_a), .mod_b(mod_b),
        .mod_result(mod_result), .mod_done(mod_done)
    );

    int          pass_cnt = 0, total_cnt = 0, fail_cnt = 0;
    int          lat_cfg = 1;
    logic [15:0] cur_mod = 16'd0;
    int          ena_cnt = 0, done_cnt = 0, stab_err = 0, ena_err = 0;
    logic [31:0] max_a = 0;
    logic        pend = 1'b0, ena_prev = 1'b0;
    int          cnt = 0;
    logic [31:0] rem_hold = 0, a_hold = 0;

    // Reduction model: answers each mod_ena with a % b after lat_cfg+1 cycles.
    always @(posedge clk) begin
        mod_done <= 1'b0;
        ena_prev <= mod_ena;
        if (done) done_cnt <= done_cnt + 1;
        if (mod_ena) begin
            ena_cnt <= ena_cnt + 1;
            if (ena_prev) ena_err <= ena_err + 1;
            if (mod_b !== {16'd0, cur_mod}) ena_err <= ena_err + 1;
            if (mod_a > max_a) max_a <= mod_a;
            pend     <= 1'b1;
            cnt      <= lat_cfg;
            a_hold   <= mod_a;
            rem_hold <= (mod_b != 0) ? mod_a % mod_b : 32'd0;
        end else if (pend) begin
            if (busy && mod_a !== a_hold) stab_err <= stab_err + 1;
            if (cnt == 0) begin
                mod_done   <= 1'b1;
                mod_result <= rem_hold;
                pend       <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m,
                          input int lat, output logic [31:0] res, output logic [31:0] err,
                          output logic [31:0] nena, output logic [31:0] ndone,
                          output logic [31:0] got, output logic [31:0] busy1);
        int ena0, done0;
        lat_cfg = lat;
        cur_mod = m;
        @(negedge clk);
        ena0 = ena_cnt;
        done0 = done_cnt;
        base = b; exponent = e; modulus = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy1 = {31'd0, busy};
        got = 0;
        for (int i = 0; i < 3000 && got == 0; i++) begin
            if (done) got = 1;
            else @(negedge clk);
        end
        res = {16'd0, result};
        err = {31'd0, error};
        repeat (3) @(negedge clk);
        nena  = ena_cnt - ena0;
        ndone = done_cnt - done0;
    endtask

    logic [31:0] r, er, ne, nd, g, b1;
    int          ena0, done0;

    initial begin
        reset = 1'b1; start = 1'b0; base = 0; exponent = 0; modulus = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_result", {16'd0, result}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_error", {31'd0, error}, 0);
        check("rst_mod_ena", {31'd0, mod_ena}, 0);
        check("rst_mod_a", mod_a, 0);
        check("rst_mod_b", mod_b, 0);

        run_op(16'd5, 16'd3, 16'd13, 1, r, er, ne, nd, g, b1);
        $display("op 5^3 mod 13 -> %0d (reqs %0d)", r, ne);
        check("t1_got_done", g, 1);
        check("t1_busy", b1, 1);
        check("t1_result", r, 8);
        check("t1_error", er, 0);
        check("t1_reqs", ne, 4);
        check("t1_done_once", nd, 1);
        check("t1_result_held", {16'd0, result}, 8);

        run_op(16'd4, 16'd13, 16'd497, 3, r, er, ne, nd, g, b1);
        $display("op 4^13 mod 497 -> %0d (reqs %0d)", r, ne);
        check("t2_result", r, 445);
        check("t2_reqs", ne, 7);
        check("t2_max_a", {31'd0, max_a <= 32'd246016}, 1);

        run_op(16'd65, 16'd17, 16'd3233, 0, r, er, ne, nd, g, b1);
        $display("op 65^17 mod 3233 -> %0d (reqs %0d)", r, ne);
        check("rsa_enc", r, 2790);
        check("rsa_enc_reqs", ne, 7);

        run_op(16'd2790, 16'd2753, 16'd3233, 2, r, er, ne, nd, g, b1);
        $display("op 2790^2753 mod 3233 -> %0d (reqs %0d)", r, ne);
        check("rsa_dec", r, 65);
        check("rsa_dec_reqs", ne, 17);

        run_op(16'd9, 16'd0, 16'd13, 1, r, er, ne, nd, g, b1);
        $display("op 9^0 mod 13 -> %0d (reqs %0d)", r, ne);
        check("exp0_result", r, 1);
        check("exp0_reqs", ne, 1);

        run_op(16'd7, 16'd0, 16'd1, 1, r, er, ne, nd, g, b1);
        $display("op 7^0 mod 1 -> %0d (reqs %0d)", r, ne);
        check("mod1_result", r, 0);
        check("mod1_reqs", ne, 1);

        run_op(16'd7, 16'd5, 16'd0, 1, r, er, ne, nd, g, b1);
        $display("op 7^5 mod 0 -> %0d err %0d (reqs %0d)", r, er, ne);
        check("mod0_got_done", g, 1);
        check("mod0_error", er, 1);
        check("mod0_result", r, 0);
        check("mod0_reqs", ne, 0);
        check("mod0_done_once", nd, 1);

        run_op(16'd6481, 16'd1, 16'd4819, 4, r, er, ne, nd, g, b1);
        $display("op 6481^1 mod 4819 -> %0d err %0d (reqs %0d)", r, er, ne);
        check("big_base_result", r, 1662);
        check("big_base_error_cleared", er, 0);
        check("big_base_reqs", ne, 2);

        // Reset while the multiply is outstanding; the model still answers afterwards.
        lat_cfg = 8;
        cur_mod = 16'd13;
        @(negedge clk);
        ena0 = ena_cnt;
        base = 16'd5; exponent = 16'd3; modulus = 16'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        g = 0;
        for (int i = 0; i < 200 && g == 0; i++) begin
            if (ena_cnt - ena0 == 2) g = 1;
            else @(negedge clk);
        end
        check("rstmid_reached_mul", g, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        done0 = done_cnt;
        ena0 = ena_cnt;
        check("rstmid_result", {16'd0, result}, 0);
        check("rstmid_busy", {31'd0, busy}, 0);
        check("rstmid_mod_a", mod_a, 0);
        check("rstmid_mod_b", mod_b, 0);
        repeat (20) @(negedge clk);
        $display("after mid-op reset: done pulses %0d, requests %0d", done_cnt - done0, ena_cnt - ena0);
        check("rstmid_no_done", done_cnt - done0, 0);
        check("rstmid_no_req", ena_cnt - ena0, 0);
        check("rstmid_idle_busy", {31'd0, busy}, 0);
        check("rstmid_idle_result", {16'd0, result}, 0);

        // A second start while busy must not disturb the running computation.
        lat_cfg = 3;
        cur_mod = 16'd13;
        @(negedge clk);
        done0 = done_cnt;
        ena0 = ena_cnt;
        base = 16'd5; exponent = 16'd3; modulus = 16'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        base = 16'd2; exponent = 16'd2; modulus = 16'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        g = 0;
        for (int i = 0; i < 500 && g == 0; i++) begin
            if (done) g = 1;
            else @(negedge clk);
        end
        r = {16'd0, result};
        repeat (3) @(negedge clk);
        $display("op 5^3 mod 13 with stray start -> %0d (reqs %0d)", r, ena_cnt - ena0);
        check("busy_start_got_done", g, 1);
        check("busy_start_result", r, 8);
        check("busy_start_reqs", ena_cnt - ena0, 4);
        check("busy_start_done_once", done_cnt - done0, 1);

        check("mod_a_stable", stab_err, 0);
        check("mod_ena_pulse_and_mod_b", ena_err, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
